// File: rtl/gyro_pkg.sv
// ---------------------------------------------------------------------------
// gyro_pkg
// Shared definitions for the SPI gyroscope reader:
//   - gyro_state_e   : transaction FSM states
//   - SPI_READ_BIT   : MSB of the command byte selects a register read
//   - SPI_FRAME_BITS : command byte plus two data bytes
//   - GYRO_ZOUT_H_ADDR : default rate register (high byte, auto-increments)
//   - read_frame()   : builds the 24-bit MOSI frame for a register read
// ---------------------------------------------------------------------------
package gyro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_DONE     = 3'd4
    } gyro_state_e;

    localparam logic [7:0] SPI_READ_BIT     = 8'h80;
    localparam int         SPI_FRAME_BITS   = 24;
    localparam logic [6:0] GYRO_ZOUT_H_ADDR = 7'h47;

    // Command byte with the read bit set, followed by 16 idle-high bits
    // while the sensor streams the two data bytes back.
    function automatic logic [23:0] read_frame(input logic [6:0] addr);
        return {SPI_READ_BIT | {1'b0, addr}, 16'hFFFF};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen
// Mode-3 SPI clock generator for a fixed 24-bit frame.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : one-cycle request; the next clk edge drives sclk low (bit 0)
//   run        : high while the frame is shifting; counts half periods
//   spi_sclk   : SPI clock, idles high
//   fall_stb   : high in the cycle whose closing edge drives sclk low
//   rise_stb   : high in the cycle whose closing edge drives sclk high
//   last_bit   : high in the final cycle of the last bit's high phase
// Each bit is CLK_DIV cycles low followed by CLK_DIV cycles high.
// ---------------------------------------------------------------------------
module spi_sclk_gen
    import gyro_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic spi_sclk,
    output logic fall_stb,
    output logic rise_stb,
    output logic last_bit
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SPI_FRAME_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SPI_FRAME_BITS - 1);

    logic          sclk_q, sclk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          half_end;

    always_comb begin
        sclk_d   = sclk_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        fall_stb = 1'b0;
        rise_stb = 1'b0;
        last_bit = 1'b0;
        half_end = (cnt_q == HALF_LAST);

        if (start) begin
            // First falling edge of the frame; bit 0 begins.
            fall_stb = 1'b1;
            sclk_d   = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
        end else if (run) begin
            if (!half_end) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                if (!sclk_q) begin
                    rise_stb = 1'b1;
                    sclk_d   = 1'b1;
                end else if (bit_q == BIT_LAST) begin
                    // Leave sclk high; the FSM moves on to CS hold.
                    last_bit = 1'b1;
                end else begin
                    fall_stb = 1'b1;
                    sclk_d   = 1'b0;
                    bit_d    = bit_q + 1'b1;
                end
            end
        end else begin
            sclk_d = 1'b1;
            cnt_d  = '0;
            bit_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
        end else begin
            sclk_q <= sclk_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
        end
    end

    assign spi_sclk = sclk_q;

endmodule

// File: rtl/gyro_spi_reader.sv
// ---------------------------------------------------------------------------
// gyro_spi_reader
// Periodically reads a 16-bit angular-rate register from an SPI gyroscope
// (MPU-6000 style, mode 3) and presents it with a one-cycle strobe.
//   clk        : system clock (rising edge)
//   reset      : asynchronous, active-low reset
//   en         : sampling enable; low holds the sample timer at 0
//   spi_miso   : serial data from the sensor
//   spi_sclk   : SPI clock, idles high
//   spi_cs_n   : chip select, active low
//   spi_mosi   : serial data to the sensor
//   raw_data   : last complete sample, two's complement
//   data_valid : one-cycle pulse when raw_data updates
//   busy       : a transaction is in progress
//   overrun    : sticky, a trigger arrived while busy (cleared by reset only)
// ---------------------------------------------------------------------------
module gyro_spi_reader
    import gyro_pkg::*;
#(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [6:0] REG_ADDR      = GYRO_ZOUT_H_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [15:0] raw_data,
    output logic        data_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);

    gyro_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] ph_q, ph_d;
    logic [23:0]   sh_q, sh_d;
    logic          mosi_q, mosi_d;
    logic [15:0]   raw_q, raw_d;
    logic          overrun_q, overrun_d;

    logic trigger;
    logic sclk_start;
    logic sclk_run;
    logic fall_stb;
    logic rise_stb;
    logic last_bit;

    // ------------------------------------------------------------------
    // Sample timer: wraps at SAMPLE_PERIOD-1 and fires a trigger there.
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = timer_q;
        trigger = 1'b0;
        if (!en) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            trigger = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM. ph_q times the CLK_DIV-long CS setup and hold.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        sclk_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_CS_SETUP;
                    ph_d    = '0;
                end
            end
            ST_CS_SETUP: begin
                if (ph_q == HALF_LAST) begin
                    state_d    = ST_SHIFT;
                    sclk_start = 1'b1;
                    ph_d       = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_CS_HOLD;
                    ph_d    = '0;
                end
            end
            ST_CS_HOLD: begin
                if (ph_q == HALF_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sclk_run = (state_q == ST_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (reset),
        .start    (sclk_start),
        .run      (sclk_run),
        .spi_sclk (spi_sclk),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb),
        .last_bit (last_bit)
    );

    // ------------------------------------------------------------------
    // One shift register serves both directions: the MSB goes out on each
    // sclk fall and MISO enters at the LSB on each sclk rise, so after 24
    // bits the low 16 bits hold the two data bytes, high byte first.
    // ------------------------------------------------------------------
    always_comb begin
        sh_d      = sh_q;
        mosi_d    = mosi_q;
        raw_d     = raw_q;
        overrun_d = overrun_q;

        if (state_q == ST_IDLE && trigger) begin
            sh_d = read_frame(REG_ADDR);
        end
        if (fall_stb) begin
            mosi_d = sh_q[23];
        end
        if (rise_stb) begin
            sh_d = {sh_q[22:0], spi_miso};
        end
        // Loaded on the edge into DONE so the new sample is visible in the
        // same cycle as data_valid; an aborted frame never gets here.
        if (state_q == ST_CS_HOLD && ph_q == HALF_LAST) begin
            raw_d = sh_q[15:0];
        end
        if (trigger && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ph_q      <= '0;
            sh_q      <= '0;
            mosi_q    <= 1'b1;
            raw_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ph_q      <= ph_d;
            sh_q      <= sh_d;
            mosi_q    <= mosi_d;
            raw_q     <= raw_d;
            overrun_q <= overrun_d;
        end
    end

    // Decoded straight from the state register so an asynchronous reset
    // releases chip select in the same instant.
    assign spi_cs_n   = !(state_q == ST_CS_SETUP || state_q == ST_SHIFT ||
                          state_q == ST_CS_HOLD);
    assign spi_mosi   = mosi_q;
    assign raw_data   = raw_q;
    assign data_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_gyro_spi_reader.sv
`timescale 1ns/1ps
module tb_gyro_spi_reader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en1, en2;
    logic miso1 = 1'b0;
    logic miso2 = 1'b0;

    logic        sclk1, cs1, mosi1, dv1, busy1, ovr1;
    logic        sclk2, cs2, mosi2, dv2, busy2, ovr2;
    logic [15:0] raw1, raw2;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .spi_miso(miso1),
        .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1),
        .raw_data(raw1), .data_valid(dv1), .busy(busy1), .overrun(ovr1)
    );

    gyro_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(60)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .spi_miso(miso2),
        .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_mosi(mosi2),
        .raw_data(raw2), .data_valid(dv2), .busy(busy2), .overrun(ovr2)
    );

    // ---------------- sensor model + protocol monitor, dut1 ----------------
    logic [15:0] resp_tab [0:7];
    initial begin
        resp_tab[0] = 16'hBEEF; resp_tab[1] = 16'h8000;
        resp_tab[2] = 16'h7FFF; resp_tab[3] = 16'h1234;
        resp_tab[4] = 16'hDEAD; resp_tab[5] = 16'h5A5A;
        resp_tab[6] = 16'h0F0F; resp_tab[7] = 16'hF0F0;
    end

    int          f_idx1 = 0, fall1 = 0, rise1 = 0, csl1 = 0, viol1 = 0;
    int          end_rise1 = 0, end_csl1 = 0;
    int          csf_cyc1 = 0, csf_cnt1 = 0, dv_cnt1 = 0, dv_cyc1 = 0;
    logic [23:0] word1 = '0, mcap1 = '0, end_mosi1 = '0;
    logic [15:0] dv_raw1 = '0;
    logic        p_cs1 = 1'b1, p_sclk1 = 1'b1, p_mosi1 = 1'b1;

    always @(negedge clk) begin
        if (!cs1 && p_cs1) begin
            word1 = {8'h00, resp_tab[f_idx1 % 8]};
            f_idx1++;
            fall1 = 0; rise1 = 0; mcap1 = '0; csl1 = 0;
            csf_cyc1 = cyc; csf_cnt1++;
        end
        if (!cs1) csl1++;
        if (cs1 && !p_cs1) begin
            end_csl1 = csl1; end_rise1 = rise1; end_mosi1 = mcap1;
        end
        if (!cs1 && !sclk1 && p_sclk1 && fall1 < 24) begin
            miso1 = word1[23 - fall1];
            fall1++;
        end
        if (!cs1 && sclk1 && !p_sclk1) begin
            mcap1 = {mcap1[22:0], mosi1};
            rise1++;
        end
        if (!cs1 && sclk1 && p_sclk1 && mosi1 !== p_mosi1) viol1++;
        if (dv1 === 1'b1) begin
            dv_cnt1++; dv_cyc1 = cyc; dv_raw1 = raw1;
        end
        p_cs1 = cs1; p_sclk1 = sclk1; p_mosi1 = mosi1;
    end

    // ---------------- sensor model + protocol monitor, dut2 ----------------
    int          fall2 = 0, rise2 = 0, csl2 = 0, viol2 = 0;
    int          end_rise2 = 0, end_csl2 = 0, dv_cnt2 = 0, dv_cyc2 = 0;
    logic [23:0] word2 = {8'h00, 16'hA5C3};
    logic [15:0] dv_raw2 = '0;
    logic        p_cs2 = 1'b1, p_sclk2 = 1'b1, p_mosi2 = 1'b1;

    always @(negedge clk) begin
        if (!cs2 && p_cs2) begin
            fall2 = 0; rise2 = 0; csl2 = 0;
        end
        if (!cs2) csl2++;
        if (cs2 && !p_cs2) begin
            end_csl2 = csl2; end_rise2 = rise2;
        end
        if (!cs2 && !sclk2 && p_sclk2 && fall2 < 24) begin
            miso2 = word2[23 - fall2];
            fall2++;
        end
        if (!cs2 && sclk2 && !p_sclk2) rise2++;
        if (!cs2 && sclk2 && p_sclk2 && mosi2 !== p_mosi2) viol2++;
        if (dv2 === 1'b1) begin
            dv_cnt2++; dv_cyc2 = cyc; dv_raw2 = raw2;
        end
        p_cs2 = cs2; p_sclk2 = sclk2; p_mosi2 = mosi2;
    end

    // ---------------- driver / wait tasks ----------------
    task automatic wait_dv1(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (dv_cnt1 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_dv2(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (dv_cnt2 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_csf1(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (csf_cnt1 >= target) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; en1 = 1'b0; en2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (sclk1 !== 1'b1) begin n_bad++; $display("FAIL rst_sclk: got %b expected 1", sclk1); end
        n_cmp++; if (cs1 !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b expected 1", cs1); end
        n_cmp++; if (mosi1 !== 1'b1) begin n_bad++; $display("FAIL rst_mosi: got %b expected 1", mosi1); end
        n_cmp++; if (raw1 !== 16'h0000) begin n_bad++; $display("FAIL rst_raw: got %h expected 0000", raw1); end
        n_cmp++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL rst_dv: got %b expected 0", dv1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy1); end
        n_cmp++; if (ovr1 !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b expected 0", ovr1); end
        n_cmp++; if (ovr2 !== 1'b0) begin n_bad++; $display("FAIL rst_overrun2: got %b expected 0", ovr2); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (cs1 !== 1'b1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL idle_no_en: cs_n=%b busy=%b expected 1/0", cs1, busy1); end
    endtask

    task automatic test_first_frame();
        int t0; bit ok; int base;
        base = dv_cnt1;
        @(posedge clk); #1;
        en1 = 1'b1; t0 = cyc;
        wait_dv1(base + 1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL f1_timeout: got no data_valid, expected one by cycle %0d", t0 + 300); end
        n_cmp++; if (csf_cyc1 !== t0 + 200) begin n_bad++; $display("FAIL f1_cs_fall: got cycle %0d expected %0d", csf_cyc1, t0 + 200); end
        n_cmp++; if (dv_cyc1 !== t0 + 300) begin n_bad++; $display("FAIL f1_dv_cycle: got %0d expected %0d", dv_cyc1, t0 + 300); end
        n_cmp++; if (raw1 !== 16'hBEEF) begin n_bad++; $display("FAIL f1_raw: got %h expected beef", raw1); end
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL f1_busy_in_done: got %b expected 1", busy1); end
        n_cmp++; if (end_mosi1[23:16] !== 8'hC7) begin n_bad++; $display("FAIL f1_mosi_cmd: got %h expected c7", end_mosi1[23:16]); end
        n_cmp++; if (end_mosi1[15:0] !== 16'hFFFF) begin n_bad++; $display("FAIL f1_mosi_fill: got %h expected ffff", end_mosi1[15:0]); end
        n_cmp++; if (end_rise1 !== 24) begin n_bad++; $display("FAIL f1_sclk_rises: got %0d expected 24", end_rise1); end
        n_cmp++; if (end_csl1 !== 100) begin n_bad++; $display("FAIL f1_cs_low_len: got %0d expected 100", end_csl1); end
        @(negedge clk); #1;
        n_cmp++; if (dv1 !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL f1_after_done: dv=%b busy=%b expected 0/0", dv1, busy1); end
        n_cmp++; if (dv_cnt1 !== base + 1) begin n_bad++; $display("FAIL f1_dv_count: got %0d expected %0d", dv_cnt1 - base, 1); end
    endtask

    task automatic test_back_to_back();
        int prev; bit ok; int base;
        base = dv_cnt1; prev = dv_cyc1;
        wait_dv1(base + 1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b1_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_raw1 !== 16'h8000) begin n_bad++; $display("FAIL b2b1_raw: got %h expected 8000", dv_raw1); end
        n_cmp++; if (dv_cyc1 - prev !== 200) begin n_bad++; $display("FAIL b2b1_spacing: got %0d expected 200", dv_cyc1 - prev); end
        prev = dv_cyc1;
        wait_dv1(base + 2, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b2_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_raw1 !== 16'h7FFF) begin n_bad++; $display("FAIL b2b2_raw: got %h expected 7fff", dv_raw1); end
        n_cmp++; if (dv_cyc1 - prev !== 200) begin n_bad++; $display("FAIL b2b2_spacing: got %0d expected 200", dv_cyc1 - prev); end
        n_cmp++; if (end_rise1 !== 24 || end_csl1 !== 100) begin n_bad++; $display("FAIL b2b_protocol: rises=%0d cs_low=%0d expected 24/100", end_rise1, end_csl1); end
        n_cmp++; if (viol1 !== 0) begin n_bad++; $display("FAIL mosi_stable: got %0d changes while sclk high, expected 0", viol1); end
    endtask

    task automatic test_en_drop();
        int csf; int t1; bit ok; int base_cs; int base_dv;
        base_cs = csf_cnt1; base_dv = dv_cnt1;
        wait_csf1(base_cs + 1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL endrop_cs_timeout: got no cs_n fall, expected one"); end
        csf = csf_cyc1;
        repeat (20) @(posedge clk);
        #1; en1 = 1'b0;
        wait_dv1(base_dv + 1, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL endrop_dv_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_cyc1 !== csf + 100) begin n_bad++; $display("FAIL endrop_dv_cycle: got %0d expected %0d", dv_cyc1, csf + 100); end
        n_cmp++; if (dv_raw1 !== 16'h1234) begin n_bad++; $display("FAIL endrop_raw: got %h expected 1234", dv_raw1); end
        base_cs = csf_cnt1;
        repeat (300) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (csf_cnt1 !== base_cs) begin n_bad++; $display("FAIL endrop_quiet: got %0d cs_n falls expected 0", csf_cnt1 - base_cs); end
        n_cmp++; if (busy1 !== 1'b0 || raw1 !== 16'h1234) begin n_bad++; $display("FAIL endrop_hold: busy=%b raw=%h expected 0/1234", busy1, raw1); end
        @(posedge clk); #1;
        en1 = 1'b1; t1 = cyc;
        wait_csf1(base_cs + 1, 300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL endrop_resume_timeout: got no cs_n fall, expected one"); end
        n_cmp++; if (csf_cyc1 !== t1 + 200) begin n_bad++; $display("FAIL endrop_resume_cycle: got %0d expected %0d", csf_cyc1, t1 + 200); end
    endtask

    task automatic test_reset_mid();
        bit ok; int base_dv; int t2;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rise1 >= 10) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_sclk_timeout: got %0d sclk rises expected 10", rise1); end
        base_dv = dv_cnt1;
        reset = 1'b0;
        #1;
        n_cmp++; if (cs1 !== 1'b1 || sclk1 !== 1'b1 || mosi1 !== 1'b1) begin n_bad++; $display("FAIL rstmid_pins: cs_n=%b sclk=%b mosi=%b expected 1/1/1", cs1, sclk1, mosi1); end
        n_cmp++; if (raw1 !== 16'h0000 || busy1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_regs: raw=%h busy=%b expected 0000/0", raw1, busy1); end
        repeat (5) @(posedge clk);
        #1; reset = 1'b1; t2 = cyc;
        @(negedge clk); #1;
        n_cmp++; if (dv_cnt1 !== base_dv) begin n_bad++; $display("FAIL rstmid_no_dv: got %0d pulses expected 0", dv_cnt1 - base_dv); end
        wait_dv1(base_dv + 1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_recover_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_cyc1 !== t2 + 300) begin n_bad++; $display("FAIL rstmid_recover_cycle: got %0d expected %0d", dv_cyc1, t2 + 300); end
        n_cmp++; if (dv_raw1 !== 16'h5A5A) begin n_bad++; $display("FAIL rstmid_recover_raw: got %h expected 5a5a", dv_raw1); end
        n_cmp++; if (end_rise1 !== 24 || end_mosi1 !== 24'hC7FFFF) begin n_bad++; $display("FAIL rstmid_recover_frame: rises=%0d mosi=%h expected 24/c7ffff", end_rise1, end_mosi1); end
        en1 = 1'b0;
    endtask

    task automatic test_overrun();
        int t3; bit ok; int base;
        base = dv_cnt2;
        @(posedge clk); #1;
        en2 = 1'b1; t3 = cyc;
        repeat (119) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (ovr2 !== 1'b0) begin n_bad++; $display("FAIL ovr_before: got %b expected 0 at cycle %0d", ovr2, cyc); end
        n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL ovr_busy: got %b expected 1", busy2); end
        @(negedge clk); #1;
        n_cmp++; if (ovr2 !== 1'b1) begin n_bad++; $display("FAIL ovr_rise: got %b expected 1 at cycle %0d", ovr2, cyc); end
        wait_dv2(base + 1, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_dv1_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_cyc2 !== t3 + 160 || dv_raw2 !== 16'hA5C3) begin n_bad++; $display("FAIL ovr_frame1: cycle=%0d raw=%h expected %0d/a5c3", dv_cyc2, dv_raw2, t3 + 160); end
        wait_dv2(base + 2, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_dv2_timeout: got no data_valid, expected one"); end
        n_cmp++; if (dv_cyc2 !== t3 + 280 || dv_raw2 !== 16'hA5C3) begin n_bad++; $display("FAIL ovr_frame2: cycle=%0d raw=%h expected %0d/a5c3", dv_cyc2, dv_raw2, t3 + 280); end
        n_cmp++; if (end_rise2 !== 24 || end_csl2 !== 100 || viol2 !== 0) begin n_bad++; $display("FAIL ovr_protocol: rises=%0d cs_low=%0d viol=%0d expected 24/100/0", end_rise2, end_csl2, viol2); end
        n_cmp++; if (ovr2 !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b expected 1", ovr2); end
        n_cmp++; if (ovr1 !== 1'b0) begin n_bad++; $display("FAIL ovr_dut1_clear: got %b expected 0", ovr1); end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation reached %0t without completing", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gyro_spi_reader.md
# gyro_spi_reader

Front-end that fetches angular-rate samples from an SPI gyroscope (register map and read protocol of the MPU-6000 family) and delivers them to the gyro integrator. Every SAMPLE_PERIOD clocks it runs one 24-bit SPI read of a 16-bit rate register. It then presents the result on `raw_data` with a one-cycle `data_valid` strobe, which drives the integrator's `raw_data` and `en` inputs directly.

## Interface
- CLK_DIV, 4: `clk` cycles per SCLK half-period; ≥2.
- SAMPLE_PERIOD, 1000: `clk` cycles between read triggers; must be ≥ 50*CLK_DIV+2.
- REG_ADDR, 7'h47: register address of the rate high byte (GYRO_ZOUT_H).
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sampling enable.
- spi_miso  input  1  serial data from sensor.
- spi_sclk  output  1  SPI clock, mode 3 (idles high).
- spi_cs_n  output  1  chip select, active low.
- spi_mosi  output  1  serial data to sensor.
- raw_data  output  16  last sample, two's complement, high byte first on wire.
- data_valid  output  1  one-cycle pulse when `raw_data` updates.
- busy  output  1  high while a transaction is in progress.
- overrun  output  1  sticky; a trigger arrived while busy.

## Operation
- Reset values:
  - `spi_sclk`=1, `spi_cs_n`=1, `spi_mosi`=1.
  - `raw_data`=0, `data_valid`=0, `busy`=0, `overrun`=0.
  - Timer=0, state IDLE.
- Sample timer:
  - Increments every cycle while `en`=1.
  - In the cycle it equals SAMPLE_PERIOD-1 it wraps to 0 and issues a trigger.
  - `en`=0 clears it to 0.
  - The first trigger therefore occurs in the SAMPLE_PERIOD-th consecutive cycle with `en` high.
- FSM states:
  - IDLE: trigger → CS_SETUP.
  - CS_SETUP: `cs_n` low for CLK_DIV cycles → SHIFT.
  - SHIFT: 24 SCLK periods → CS_HOLD.
  - CS_HOLD: `cs_n` still low, `sclk` high, CLK_DIV cycles → DONE.
  - DONE: 1 cycle, `cs_n` high, pulse `data_valid` → IDLE.
- Frame layout: MOSI sends 8'h80|REG_ADDR (read bit set) MSB first, then 16 bits of 1.
- Bits 8..23 on MISO form `raw_data[15:0]`, MSB first. The sensor auto-increments from the high byte to the low byte.
- Bit timing, mode 3:
  - Each bit is CLK_DIV cycles with `sclk` low, then CLK_DIV cycles with `sclk` high.
  - `spi_mosi` changes only in the cycle `sclk` falls.
  - MISO is captured into the shift register on the `clk` edge that drives `sclk` high.
- `raw_data` loads from the shift register only in DONE and is held otherwise. A partial frame never reaches `raw_data`.
- `busy` = state ≠ IDLE.

## Timing
- Trigger in cycle T: `cs_n` falls at T+1.
- First `sclk` fall at T+1+CLK_DIV.
- `data_valid`=1 and new `raw_data` in cycle T+1+50*CLK_DIV (201 for the default CLK_DIV).
- `busy` is high for cycles T+1 … T+1+50*CLK_DIV.
- Trigger while busy: trigger is dropped, `overrun` set next cycle, transaction unaffected. `overrun` is cleared only by reset.
- `en` falls mid-transaction: the transaction completes and `data_valid` still pulses. The timer stays at 0 until `en` returns.
- Reset asserted mid-transaction: outputs take their reset values immediately (asynchronous). `cs_n` rises at once with no partial `data_valid`.
- Back-to-back reads are at least SAMPLE_PERIOD cycles apart, so `cs_n` is high for at least SAMPLE_PERIOD-50*CLK_DIV-1 cycles between frames.

## Structure
- Package `gyro_pkg`: FSM state enum, SPI_READ_BIT (8'h80), SPI_FRAME_BITS (24), default REG_ADDR.
- Sub-module `spi_sclk_gen`:
  - Half-period counter, enabled in SHIFT.
  - Drives `spi_sclk`.
  - Emits one-cycle `fall_stb` / `rise_stb` and a bit counter terminal `last_bit`.
- Top level holds the sample timer, FSM, 24-bit shift register, `raw_data` register and `overrun`.

## Test plan
1. CLK_DIV=2, SAMPLE_PERIOD=200, `en`=1 from cycle 0, MISO model returns 16'hBEEF.
   - Trigger at cycle 199; `data_valid` pulses once at cycle 300 with `raw_data`=16'hBEEF.
   - MOSI byte observed = 8'hC7.
2. Same setup, model returns 16'h8000 then 16'h7FFF on successive frames.
   - `raw_data` shows 16'h8000, then 16'h7FFF; the valid pulses are exactly 200 cycles apart.
3. `en` dropped 20 cycles after `cs_n` falls.
   - The frame completes with `data_valid` at the normal cycle.
   - No further `cs_n` activity while `en`=0; the next trigger comes 200 cycles after `en` returns.
4. `reset` asserted at the 10th SCLK of a frame.
   - `cs_n`, `sclk` and `mosi` go to 1 within the same cycle; `raw_data`=0 and no `data_valid`.
   - After release with `en`=1, a normal frame occurs.
5. SAMPLE_PERIOD=60, CLK_DIV=2 (illegal spacing).
   - `overrun` rises one cycle after the first trigger that lands while busy, and stays 1.
   - Frames continue uncorrupted.
6. Protocol checker on all frames:
   - `cs_n` low exactly 50*CLK_DIV cycles.
   - 24 `sclk` rising edges per frame.
   - `mosi` stable while `sclk` is high.
